// File: rtl/varcic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : varcic_pkg
// Purpose  : Shared constants and elaboration-time helpers for the
//            multi-channel variable-rate CIC decimator.
// Revision : 1.0 - initial release
// ============================================================================
package varcic_pkg;

  // Width of the runtime rate input and of the rate counter
  localparam int RATE_W     = 8;
  // Width of one entry of the gain-shift lookup table
  localparam int SHIFT_W    = 8;
  // Width of the signed LSB-drop amount handed to each lane
  localparam int DROP_W     = 10;
  // Token pipeline bit written by the rate counter; bit k then enables
  // comb stage k, and bit STAGES enables the output register
  localparam int TOK_INJECT = 0;

  // Smallest r with 2**r >= v (bounded so a huge argument cannot hang elaboration)
  function automatic int clog2(input longint unsigned v);
    longint unsigned p;
    int              r;
    p = 64'd1;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if (p < v) begin
        p = p << 1;
        r = r + 1;
      end
    end
    return r;
  endfunction

  // Bit growth of an N-stage CIC at rate R: smallest s with 2**s >= R**N
  function automatic int cic_shift(input int r, input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'(r);
    end
    return clog2(p);
  endfunction

  // Accumulator width that holds the worst-case gain at the largest rate
  function automatic int acc_width(input int in_w, input int n, input int max_dec);
    return in_w + cic_shift(max_dec, n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/varcic_if.sv
`default_nettype none
// ============================================================================
// Module   : varcic_if
// Purpose  : Sample-stream and status bundle of the CIC decimator.
//            master = sample source / result sink, slave = decimator.
// Revision : 1.0 - initial release
// ============================================================================
interface varcic_if #(
  parameter int NCH       = 2,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
);
  logic [7:0]               decimation;
  logic                     in_strobe;
  logic [NCH*IN_WIDTH-1:0]  in_data;
  logic                     out_strobe;
  logic [NCH*OUT_WIDTH-1:0] out_data;
  logic [NCH-1:0]           out_sat;
  logic                     rate_err;

  modport master (
    output decimation, in_strobe, in_data,
    input  out_strobe, out_data, out_sat, rate_err
  );

  modport slave (
    input  decimation, in_strobe, in_data,
    output out_strobe, out_data, out_sat, rate_err
  );
endinterface
`default_nettype wire

// File: rtl/varcic_lane.sv
`default_nettype none
// ============================================================================
// Module   : varcic_lane
// Purpose  : One channel of the CIC decimator: pipelined integrators,
//            token-driven combs, round-half-up scaling and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module varcic_lane
  import varcic_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int ACC_WIDTH = 32
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  input  wire logic                        clr,
  input  wire logic                        in_en,
  input  wire logic signed [IN_WIDTH-1:0]  in_sample,
  input  wire logic [STAGES:0]             tok,
  input  wire logic signed [DROP_W-1:0]    drop,
  output logic signed [OUT_WIDTH-1:0]      out_sample,
  output logic                             out_sat
);

  // Headroom for the left shift when the output is wider than the data
  localparam int WIDE = ACC_WIDTH + OUT_WIDTH + 2;
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  acc_t integ_q [STAGES];
  acc_t integ_d [STAGES];
  acc_t comb_q  [STAGES];
  acc_t comb_d  [STAGES];
  acc_t dly_q   [STAGES];
  acc_t dly_d   [STAGES];
  acc_t comb_src[STAGES];

  logic signed [OUT_WIDTH-1:0] out_q, out_d;
  logic                        sat_q, sat_d;

  logic signed [WIDE-1:0]      wide;
  logic signed [WIDE-1:0]      rnd;
  logic signed [WIDE-1:0]      rounded;
  logic [DROP_W-1:0]           rsh;
  logic [DROP_W-1:0]           lsh;
  logic                        pos_drop;
  logic signed [OUT_WIDTH-1:0] clip_val;
  logic                        clip_flag;

  // Integrators advance on every accepted sample; each comb stage moves only with its token
  always_comb begin
    comb_src[0] = integ_q[STAGES-1];
    for (int k = 1; k < STAGES; k++) begin
      comb_src[k] = comb_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      integ_d[k] = integ_q[k];
      comb_d[k]  = comb_q[k];
      dly_d[k]   = dly_q[k];
    end
    if (clr) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_d[k] = '0;
        comb_d[k]  = '0;
        dly_d[k]   = '0;
      end
    end else begin
      if (in_en) begin
        // Later stages take the previous value of the stage before them
        integ_d[0] = integ_q[0] + ACC_WIDTH'(in_sample);
        for (int k = 1; k < STAGES; k++) begin
          integ_d[k] = integ_q[k] + integ_q[k-1];
        end
      end
      for (int k = 0; k < STAGES; k++) begin
        if (tok[k]) begin
          comb_d[k] = comb_src[k] - dly_q[k];
          dly_d[k]  = comb_src[k];
        end
      end
    end
  end

  // Scale the last comb by the rate-dependent drop, round half up, then clip
  always_comb begin
    wide     = WIDE'(comb_q[STAGES-1]);
    pos_drop = !drop[DROP_W-1] && (drop != '0);
    rsh      = drop;
    lsh      = -drop;
    rnd      = '0;
    if (pos_drop) begin
      rnd     = WIDE'(1) << (rsh - 1'b1);
      rounded = (wide + rnd) >>> rsh;
    end else begin
      rounded = wide <<< lsh;
    end
    clip_flag = 1'b0;
    clip_val  = rounded[OUT_WIDTH-1:0];
    if (rounded > WIDE'(OUT_MAX)) begin
      clip_val  = OUT_MAX;
      clip_flag = 1'b1;
    end else if (rounded < WIDE'(OUT_MIN)) begin
      clip_val  = OUT_MIN;
      clip_flag = 1'b1;
    end
    out_d = out_q;
    sat_d = sat_q;
    // A token reaching the end during a restart belongs to the old rate
    if (tok[STAGES] && !clr) begin
      out_d = clip_val;
      sat_d = clip_flag;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
      end
      out_q <= '0;
      sat_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= integ_d[k];
        comb_q[k]  <= comb_d[k];
        dly_q[k]   <= dly_d[k];
      end
      out_q <= out_d;
      sat_q <= sat_d;
    end
  end

  assign out_sample = out_q;
  assign out_sat    = sat_q;

endmodule
`default_nettype wire

// File: rtl/varcic_mc.sv
`default_nettype none
// ============================================================================
// Module   : varcic_mc
// Purpose  : NCH-lane CIC decimator with runtime rate 1..MAX_DEC, shared
//            rate counter/token pipeline, restart on rate change and a
//            rate-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module varcic_mc
  import varcic_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int NCH       = 2,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int MAX_DEC   = 40
) (
  input  wire logic clock,
  input  wire logic reset,
  varcic_if.slave   bus
);

  localparam int ACC_WIDTH = acc_width(IN_WIDTH, STAGES, MAX_DEC);
  localparam int LUT_BITS  = SHIFT_W * (MAX_DEC + 1);

  // Gain shift for every supported rate; entry 0 is unused
  function automatic logic [LUT_BITS-1:0] build_shift_lut();
    logic [LUT_BITS-1:0] lut;
    lut = '0;
    for (int r = 1; r <= MAX_DEC; r++) begin
      lut[r*SHIFT_W +: SHIFT_W] = SHIFT_W'(cic_shift(r, STAGES));
    end
    return lut;
  endfunction

  localparam logic [LUT_BITS-1:0] SHIFT_LUT = build_shift_lut();

  function automatic logic rate_ok(input logic [RATE_W-1:0] r);
    return (r != '0) && (int'(r) <= MAX_DEC);
  endfunction

  logic [RATE_W-1:0]       dec_q, dec_d;
  logic [RATE_W-1:0]       cnt_q, cnt_d;
  logic [STAGES:0]         tok_q, tok_d;
  logic                    out_strobe_q, out_strobe_d;
  logic                    rate_err_q, rate_err_d;

  logic                    restart;
  logic                    dec_valid;
  logic                    in_en;
  logic [RATE_W-1:0]       dec_idx;
  logic [SHIFT_W-1:0]      shift_w;
  logic signed [DROP_W-1:0] drop;

  logic [NCH*OUT_WIDTH-1:0] out_data_w;
  logic [NCH-1:0]           out_sat_w;

  // Rate counter, token injection and one-cycle restart on a rate change
  always_comb begin
    restart      = (bus.decimation != dec_q);
    dec_valid    = rate_ok(dec_q);
    in_en        = bus.in_strobe && !restart;
    dec_d        = dec_q;
    cnt_d        = cnt_q;
    tok_d        = {tok_q[STAGES-1:0], 1'b0};
    out_strobe_d = tok_q[STAGES];
    rate_err_d   = !rate_ok(bus.decimation);
    if (restart) begin
      dec_d        = bus.decimation;
      cnt_d        = '0;
      tok_d        = '0;
      out_strobe_d = 1'b0;
    end else if (!dec_valid) begin
      cnt_d = '0;
    end else if (bus.in_strobe) begin
      if (cnt_q == dec_q - 8'd1) begin
        cnt_d             = '0;
        tok_d[TOK_INJECT] = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Gain normalisation: LSBs to drop for the active rate
  always_comb begin
    dec_idx = dec_valid ? dec_q : '0;
    shift_w = SHIFT_LUT[int'(dec_idx)*SHIFT_W +: SHIFT_W];
    drop    = DROP_W'(IN_WIDTH - OUT_WIDTH) + DROP_W'(shift_w);
  end

  // Control registers
  always_ff @(posedge clock) begin
    if (reset) begin
      dec_q        <= '0;
      cnt_q        <= '0;
      tok_q        <= '0;
      out_strobe_q <= 1'b0;
      rate_err_q   <= 1'b0;
    end else begin
      dec_q        <= dec_d;
      cnt_q        <= cnt_d;
      tok_q        <= tok_d;
      out_strobe_q <= out_strobe_d;
      rate_err_q   <= rate_err_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    varcic_lane #(
      .STAGES    (STAGES),
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk        (clock),
      .rst        (reset),
      .clr        (restart),
      .in_en      (in_en),
      .in_sample  (bus.in_data[g*IN_WIDTH +: IN_WIDTH]),
      .tok        (tok_q),
      .drop       (drop),
      .out_sample (out_data_w[g*OUT_WIDTH +: OUT_WIDTH]),
      .out_sat    (out_sat_w[g])
    );
  end

  assign bus.out_strobe = out_strobe_q;
  assign bus.out_data   = out_data_w;
  assign bus.out_sat    = out_sat_w;
  assign bus.rate_err   = rate_err_q;

endmodule
`default_nettype wire
